// File: rtl/chu_gpo_blink_pkg.sv
// Shared constants for the GPO blink slot core: register word addresses and channel limit.
package chu_gpo_blink_pkg;
  localparam int ADDR_W = 5;
  localparam int MAX_CH = 16;

  localparam logic [ADDR_W-1:0] ADDR_DATA        = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_EN    = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS      = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_SYNC        = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD_BASE = 5'd16;
endpackage

// File: rtl/chu_gpo_blink_if.sv
// MMIO slot bus for the GPO blink core; the bus master drives strobes, the slot returns rd_data.
interface chu_gpo_blink_if;
  import chu_gpo_blink_pkg::*;

  logic              cs;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_gpo_blink_channel.sv
// One blink channel: counts ticks within the current half-period and flips phase at its end.
module blink_channel #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                restart,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // >= rather than == so a period shrunk below cnt ends the half on the next tick
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (tick && en) begin
      if (period == '0) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt >= period - PERIOD_W'(1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/chu_gpo_blink.sv
// GPO slot core: W output pins, each static or blinking at a per-channel half-period in ticks.
module chu_gpo_blink
  import chu_gpo_blink_pkg::*;
#(
  parameter int W        = 16,
  parameter int TICK_DIV = 100_000,
  parameter int PERIOD_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  chu_gpo_blink_if.slave bus,
  output logic [W-1:0]  dout
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [W-1:0]        data_reg;
  logic [W-1:0]        blink_en;
  logic [PERIOD_W-1:0] period [W];
  logic [PRE_W-1:0]    prescaler;
  logic                tick;
  logic                wr_en;
  logic                sync_wr;
  logic                en_wr;
  logic [W-1:0]        restart;
  logic [W-1:0]        phase;
  logic [31:0]         rd_mux;
  logic                unused_bus;

  assign wr_en   = bus.cs && bus.write;
  assign sync_wr = wr_en && (bus.addr == ADDR_SYNC);
  assign en_wr   = wr_en && (bus.addr == ADDR_BLINK_EN);
  assign tick    = (prescaler == PRE_W'(TICK_DIV - 1));

  // Only channels enabled 0->1 restart; already-blinking channels keep their place.
  assign restart = {W{sync_wr}} | ({W{en_wr}} & bus.wr_data[W-1:0] & ~blink_en);

  always_ff @(posedge clk) begin
    if (reset || sync_wr || tick) prescaler <= '0;
    else                          prescaler <= prescaler + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      blink_en <= '0;
      for (int i = 0; i < W; i++) period[i] <= '0;
    end else if (wr_en) begin
      if (bus.addr == ADDR_DATA)     data_reg <= bus.wr_data[W-1:0];
      if (bus.addr == ADDR_BLINK_EN) blink_en <= bus.wr_data[W-1:0];
      for (int i = 0; i < W; i++) begin
        if (bus.addr == ADDR_PERIOD_BASE + 5'(i)) period[i] <= bus.wr_data[PERIOD_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_ch
    blink_channel #(.PERIOD_W(PERIOD_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .restart (restart[g]),
      .en      (blink_en[g]),
      .period  (period[g]),
      .phase   (phase[g])
    );
  end

  assign dout = data_reg & (~blink_en | phase);

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_DATA:     rd_mux = 32'(data_reg);
      ADDR_BLINK_EN: rd_mux = 32'(blink_en);
      ADDR_STATUS:   rd_mux = 32'(dout);
      default:       rd_mux = '0;
    endcase
    for (int i = 0; i < W; i++) begin
      if (bus.addr == ADDR_PERIOD_BASE + 5'(i)) rd_mux = 32'(period[i]);
    end
  end

  assign bus.rd_data = rd_mux;

  // read strobe is part of the slot bus but reads are purely address-driven
  assign unused_bus = &{1'b0, bus.read, bus.wr_data};

endmodule

// File: tb/tb_chu_gpo_blink.sv
// Self-checking bench for chu_gpo_blink: register table, blink timing sequences, random vs model.
module tb_chu_gpo_blink;
  localparam int W        = 4;
  localparam int TICK_DIV = 4;
  localparam int PERIOD_W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dout;

  chu_gpo_blink_if bus();

  chu_gpo_blink #(.W(W), .TICK_DIV(TICK_DIV), .PERIOD_W(PERIOD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per channel, ticks elapsed in the current half and whether it is the ON half.
  int           m_pre;
  logic [W-1:0] m_data;
  logic [W-1:0] m_en;
  int           m_per [W];
  int           m_el  [W];
  bit           m_on  [W];

  function automatic logic [W-1:0] m_dout();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = m_data[i] && (!m_en[i] || m_on[i]);
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return 32'(m_data);
    if (ai == 1) return 32'(m_en);
    if (ai == 2) return 32'(m_dout());
    if (ai >= 16 && ai < 16 + W) return 32'(m_per[ai-16]);
    return 32'd0;
  endfunction

  task automatic model_step();
    bit mw, mt, ms;
    int ai;
    if (reset) begin
      m_pre  = 0;
      m_data = '0;
      m_en   = '0;
      for (int i = 0; i < W; i++) begin
        m_per[i] = 0;
        m_el[i]  = 0;
        m_on[i]  = 1'b1;
      end
    end else begin
      ai = int'(bus.addr);
      mw = bus.cs && bus.write;
      mt = (m_pre == TICK_DIV - 1);
      ms = mw && ai == 3;
      for (int i = 0; i < W; i++) begin
        if (ms || (mw && ai == 1 && bus.wr_data[i] && !m_en[i])) begin
          m_el[i] = 0;
          m_on[i] = 1'b1;
        end else if (mt && m_en[i]) begin
          if (m_per[i] == 0) begin
            m_el[i] = 0;
            m_on[i] = 1'b0;
          end else begin
            m_el[i]++;
            if (m_el[i] >= m_per[i]) begin
              m_el[i] = 0;
              m_on[i] = !m_on[i];
            end
          end
        end
      end
      m_pre = ms ? 0 : (m_pre + 1) % TICK_DIV;
      if (mw) begin
        if (ai == 0) m_data = bus.wr_data[W-1:0];
        if (ai == 1) m_en   = bus.wr_data[W-1:0];
        if (ai >= 16 && ai < 16 + W) m_per[ai-16] = int'(bus.wr_data[PERIOD_W-1:0]);
      end
    end
  endtask

  // Every clock advance goes through here so the model sees the same inputs as the DUT edge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit w, input logic [4:0] a, input logic [31:0] d);
    bus.cs      = c;
    bus.write   = w;
    bus.read    = c && !w;
    bus.addr    = a;
    bus.wr_data = d;
  endtask

  task automatic cyc(input bit c, input bit w, input logic [4:0] a, input logic [31:0] d);
    drive(c, w, a, d);
    step();
    drive(1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(nm, bus.rd_data, exp);
  endtask

  task automatic model_chk(input string nm);
    chk({nm, " dout"}, 32'(dout), 32'(m_dout()));
    chk({nm, " rd"}, bus.rd_data, m_read(bus.addr));
  endtask

  task automatic measure_runs(input int bitn, input int ncyc, input int exp_len, input string nm);
    logic prev;
    int   run, nch;
    prev = dout[bitn];
    run  = 0;
    nch  = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      model_chk(nm);
      if (dout[bitn] !== prev) begin
        if (nch >= 1) chk({nm, " half length"}, 32'(run), 32'(exp_len));
        nch++;
        run  = 1;
        prev = dout[bitn];
      end else begin
        run++;
      end
    end
    chk({nm, " toggled"}, 32'(nch >= 3), 32'd1);
  endtask

  typedef struct {
    bit           cs;
    bit           wr;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic [4:0]   raddr;
    logic [31:0]  exp_rd;
    logic [W-1:0] exp_dout;
  } vec_t;

  function automatic vec_t mk(input bit cs, input bit wr, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [31:0] er, input logic [W-1:0] ed);
    vec_t v;
    v.cs = cs; v.wr = wr; v.waddr = wa; v.wdata = wd;
    v.raddr = ra; v.exp_rd = er; v.exp_dout = ed;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] addr_pool [10];
    int         k;
    bit         found;
    logic [4:0] ra;
    logic [31:0] rd;

    addr_pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};

    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    step();
    chk("reset first edge dout", 32'(dout), 32'd0);
    step();
    reset = 1'b0;

    // Static register table: blinking stays disabled so every expectation is a constant.
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd0,  32'h0,  4'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd1,  32'h0,  4'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd2,  32'h0,  4'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd16, 32'h0,  4'h0));
    vecs.push_back(mk(1, 1, 5'd0,  32'hA,        5'd2,  32'hA,  4'hA));
    vecs.push_back(mk(1, 1, 5'd0,  32'hFFFFFFF5, 5'd0,  32'h5,  4'h5));
    vecs.push_back(mk(1, 1, 5'd16, 32'h1234,     5'd16, 32'h34, 4'h5));
    vecs.push_back(mk(1, 1, 5'd19, 32'hAB,       5'd19, 32'hAB, 4'h5));
    vecs.push_back(mk(1, 1, 5'd20, 32'hFF,       5'd20, 32'h0,  4'h5));
    vecs.push_back(mk(1, 1, 5'd5,  32'hFF,       5'd5,  32'h0,  4'h5));
    vecs.push_back(mk(1, 1, 5'd2,  32'hF,        5'd2,  32'h5,  4'h5));
    vecs.push_back(mk(1, 1, 5'd3,  32'hFFFFFFFF, 5'd3,  32'h0,  4'h5));
    vecs.push_back(mk(0, 1, 5'd0,  32'hF,        5'd0,  32'h5,  4'h5));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd16, 32'h34, 4'h5));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd1,  32'h0,  4'h5));
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,        5'd17, 32'h0,  4'h5));

    for (int v = 0; v < vecs.size(); v++) begin
      cyc(vecs[v].cs, vecs[v].wr, vecs[v].waddr, vecs[v].wdata);
      rd_chk($sformatf("table[%0d] rd", v), vecs[v].raddr, vecs[v].exp_rd);
      chk($sformatf("table[%0d] dout", v), 32'(dout), 32'(vecs[v].exp_dout));
    end

    // Channel 0 blinking with PERIOD=3: 12 clk ON, 12 clk OFF.
    wr(5'd19, 32'd0);
    wr(5'd16, 32'd3);
    wr(5'd0, 32'd1);
    wr(5'd1, 32'd1);
    measure_runs(0, 80, 12, "blink p3");

    // PERIOD=0 holds low after the first tick, then PERIOD=1 toggles every tick.
    wr(5'd17, 32'd0);
    wr(5'd0, 32'd2);
    wr(5'd1, 32'd2);
    idle(5);
    for (int c = 0; c < 10; c++) begin
      chk("period0 held low", 32'(dout[1]), 32'd0);
      model_chk("period0");
      step();
    end
    wr(5'd17, 32'd1);
    measure_runs(1, 30, 4, "blink p1");

    // Shrinking PERIOD below the running count toggles on the very next tick.
    wr(5'd1, 32'd0);
    wr(5'd16, 32'd10);
    wr(5'd0, 32'd1);
    wr(5'd1, 32'd1);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (m_el[0] == 7) found = 1'b1;
      else step();
    end
    chk("shrink reached cnt7", 32'(found), 32'd1);
    chk("shrink still on", 32'(dout[0]), 32'd1);
    wr(5'd16, 32'd2);
    k = 0;
    found = 1'b0;
    for (int c = 1; c <= 8 && !found; c++) begin
      step();
      model_chk("shrink");
      if (dout[0] !== 1'b1) begin
        found = 1'b1;
        k = c;
      end
    end
    chk("shrink toggle delay", 32'(k), 32'd3);

    // Two channels out of phase, SYNC on a tick edge realigns both.
    wr(5'd1, 32'd0);
    wr(5'd16, 32'd2);
    wr(5'd17, 32'd2);
    wr(5'd0, 32'd3);
    wr(5'd1, 32'd1);
    idle(5);
    wr(5'd1, 32'd3);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dout[0] !== dout[1]) found = 1'b1;
      else step();
    end
    chk("channels out of phase", 32'(found), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      if (m_pre == TICK_DIV - 1) found = 1'b1;
      else step();
    end
    chk("sync found tick slot", 32'(found), 32'd1);
    wr(5'd3, 32'hDEADBEEF);
    chk("sync both on", 32'(dout), 32'h3);
    k = 0;
    found = 1'b0;
    for (int c = 1; c <= 12 && !found; c++) begin
      step();
      model_chk("sync");
      if (dout !== 4'h3) begin
        found = 1'b1;
        k = c;
      end
    end
    chk("sync first toggle", 32'(k), 32'd8);
    chk("sync both toggled", 32'(dout), 32'h0);

    // Random traffic against the model, including occasional SYNC and reset.
    for (int c = 0; c < 400; c++) begin
      model_chk("random");
      reset = ($urandom_range(0, 99) == 0);
      ra = addr_pool[$urandom_range(0, 9)];
      rd = (ra >= 5'd16) ? 32'($urandom_range(0, 4)) : $urandom;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, ra, rd);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    step();
    model_chk("random end");

    // Reset mid-blink clears everything on that edge.
    wr(5'd16, 32'd2);
    wr(5'd0, 32'd1);
    wr(5'd1, 32'd1);
    idle(6);
    reset = 1'b1;
    step();
    chk("midreset dout", 32'(dout), 32'd0);
    rd_chk("midreset blink_en", 5'd1, 32'd0);
    rd_chk("midreset period0", 5'd16, 32'd0);
    rd_chk("midreset data", 5'd0, 32'd0);
    reset = 1'b0;
    step();
    model_chk("after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
